// File: rtl/dev_a_pkg.sv
// Shared types and constants for the DevA byte-link transmitter.
package dev_a_pkg;

    localparam int BYTE_W      = 8;
    localparam int DEF_NBYTES  = 8;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dev_a_if.sv
// Word-in / byte-out handshake bundle between a producer, dev_a_tx and the DevB receiver.
interface dev_a_if #(
    parameter int NBYTES = dev_a_pkg::DEF_NBYTES
) ();
    import dev_a_pkg::*;

    logic [BYTE_W*NBYTES-1:0] data64;
    logic                     wordValid;
    logic                     wordAccepted;
    logic [BYTE_W-1:0]        sharedBus;
    logic                     readyA;
    logic                     acceptedB;
    logic                     doneA;
    logic                     errA;

    modport master (
        input  data64, wordValid, acceptedB,
        output wordAccepted, sharedBus, readyA, doneA, errA
    );

    modport slave (
        output data64, wordValid, acceptedB,
        input  wordAccepted, sharedBus, readyA, doneA, errA
    );

endinterface

// File: rtl/dev_a_piso.sv
// Parallel-in serial-out register: loads a word, shifts left one byte per request, presents its top byte.
module dev_a_piso
    import dev_a_pkg::*;
#(
    parameter int NBYTES = DEF_NBYTES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     shift,
    input  logic [BYTE_W*NBYTES-1:0] din,
    output logic [BYTE_W-1:0]        dout
);
    localparam int W = BYTE_W * NBYTES;

    logic [W-1:0] sreg_q, sreg_d;

    // Zeros shift in from the bottom, so the top byte reads 0 once the word is drained.
    always_comb begin
        sreg_d = sreg_q;
        if (load) begin
            sreg_d = din;
        end else if (shift) begin
            sreg_d = {sreg_q[W-BYTE_W-1:0], {BYTE_W{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign dout = sreg_q[W-1 -: BYTE_W];

endmodule

// File: rtl/dev_a_tx.sv
// DevA transmitter: latches a word, streams it MSB byte first under readyA, then waits for acceptedB.
// Optional acknowledge timeout enabled by defining DEVA_TIMEOUT_EN.
module dev_a_tx
    import dev_a_pkg::*;
#(
    parameter int NBYTES  = DEF_NBYTES,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic     clkA,
    input logic     rst,
    dev_a_if.master bus
);
    localparam int               CNT_W    = cnt_width(NBYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_q, rdy_d;
    logic             acc_q, acc_d;
    logic             done_q, done_d;
    logic             load, shift;

`ifdef DEVA_TIMEOUT_EN
    localparam int               TMO_W    = cnt_width(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    dev_a_piso #(
        .NBYTES (NBYTES)
    ) u_piso (
        .clk   (clkA),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (bus.data64),
        .dout  (bus.sharedBus)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdy_d   = rdy_q;
        acc_d   = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
`ifdef DEVA_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.wordValid) begin
                    load    = 1'b1;
                    acc_d   = 1'b1;
                    rdy_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // The final shift also empties the register, which blanks the bus in WAIT_ACK.
                shift = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    rdy_d   = 1'b0;
                    state_d = ST_WAIT_ACK;
`ifdef DEVA_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            ST_WAIT_ACK: begin
                if (bus.acceptedB) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
`ifdef DEVA_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            default: begin
                rdy_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clkA) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            acc_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
        end
    end

`ifdef DEVA_TIMEOUT_EN
    always_ff @(posedge clkA) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign bus.errA = err_q;
`else
    assign bus.errA = 1'b0;
`endif

    assign bus.readyA       = rdy_q;
    assign bus.wordAccepted = acc_q;
    assign bus.doneA        = done_q;

endmodule

// File: tb/tb_dev_a_tx.sv
// Bench for dev_a_tx: timeline model checked every cycle plus directed literal checks.
module tb_dev_a_tx;

    localparam int NB   = 8;
    localparam int TMO  = 4;
    localparam int RING = 64;
`ifdef DEVA_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dev_a_if #(.NBYTES(NB)) ifa ();
    dev_a_if #(.NBYTES(2))  ifb ();

    dev_a_tx #(.NBYTES(NB), .TIMEOUT(TMO)) u_dut  (.clkA(clk), .rst(rst), .bus(ifa));
    dev_a_tx #(.NBYTES(2))                 u_dut2 (.clkA(clk), .rst(rst), .bus(ifb));

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Expected outputs per clock edge: slot t holds what the outputs must be after edge t.
    bit         e_rdy  [RING];
    bit         e_acc  [RING];
    bit         e_done [RING];
    bit         e_err  [RING];
    logic [7:0] e_bus  [RING];
    bit         m_idle;
    int         m_wait_first;
    int         edge_n;

    function automatic void clear_slot(input int t);
        e_rdy[t % RING]  = 1'b0;
        e_acc[t % RING]  = 1'b0;
        e_done[t % RING] = 1'b0;
        e_err[t % RING]  = 1'b0;
        e_bus[t % RING]  = 8'h00;
    endfunction

    task automatic model_step(input int t);
        logic [63:0] w;
        if (rst) begin
            for (int k = 0; k < 16; k++) clear_slot(t + k);
            m_idle = 1'b1;
        end else if (m_idle) begin
            if (ifa.wordValid) begin
                w = ifa.data64;
                e_acc[t % RING] = 1'b1;
                for (int k = 0; k < NB; k++) begin
                    e_rdy[(t + k) % RING] = 1'b1;
                    e_bus[(t + k) % RING] = w[8*(NB-k)-1 -: 8];
                end
                m_wait_first = t + NB + 1;
                m_idle = 1'b0;
            end
        end else if (t >= m_wait_first) begin
            if (ifa.acceptedB) begin
                e_done[t % RING] = 1'b1;
                m_idle = 1'b1;
            end else if (TMO_EN && (t - m_wait_first + 1 == TMO)) begin
                e_err[t % RING] = 1'b1;
                m_idle = 1'b1;
            end
        end
    endtask

    task automatic model_compare(input int t);
        chk("model_readyA",       {63'd0, ifa.readyA},       {63'd0, e_rdy[t % RING]});
        chk("model_wordAccepted", {63'd0, ifa.wordAccepted}, {63'd0, e_acc[t % RING]});
        chk("model_doneA",        {63'd0, ifa.doneA},        {63'd0, e_done[t % RING]});
        chk("model_errA",         {63'd0, ifa.errA},         {63'd0, e_err[t % RING]});
        chk("model_sharedBus",    {56'd0, ifa.sharedBus},    {56'd0, e_bus[t % RING]});
        clear_slot(t);
    endtask

    initial begin : model_proc
        m_idle = 1'b1;
        m_wait_first = 0;
        edge_n = 0;
        for (int k = 0; k < RING; k++) clear_slot(k);
        forever begin
            @(posedge clk);
            edge_n++;
            model_step(edge_n);
            @(negedge clk);
            model_compare(edge_n);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    logic [7:0] exp_b [8];
    int         gap;
    bit         seen;

    initial begin : stim
        rst = 1'b1;
        ifa.data64 = '0; ifa.wordValid = 1'b0; ifa.acceptedB = 1'b0;
        ifb.data64 = '0; ifb.wordValid = 1'b0; ifb.acceptedB = 1'b0;
        exp_b[0] = 8'h01; exp_b[1] = 8'h23; exp_b[2] = 8'h45; exp_b[3] = 8'h67;
        exp_b[4] = 8'h89; exp_b[5] = 8'hAB; exp_b[6] = 8'hCD; exp_b[7] = 8'hEF;

        tick(2);
        chk("reset_readyA",       {63'd0, ifa.readyA},       64'd0);
        chk("reset_sharedBus",    {56'd0, ifa.sharedBus},    64'd0);
        chk("reset_wordAccepted", {63'd0, ifa.wordAccepted}, 64'd0);
        chk("reset_doneA",        {63'd0, ifa.doneA},        64'd0);
        chk("reset_errA",         {63'd0, ifa.errA},         64'd0);
        rst = 1'b0;
        tick(2);

        // Basic word
        ifa.data64 = 64'h0123_4567_89AB_CDEF;
        ifa.wordValid = 1'b1;
        tick(1);
        chk("basic_accept", {63'd0, ifa.wordAccepted}, 64'd1);
        ifa.wordValid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick(1);
            chk("basic_readyA", {63'd0, ifa.readyA}, 64'd1);
            chk("basic_byte",   {56'd0, ifa.sharedBus}, {56'd0, exp_b[k]});
        end
        tick(1);
        chk("basic_readyA_low", {63'd0, ifa.readyA}, 64'd0);
        chk("basic_bus_zero",   {56'd0, ifa.sharedBus}, 64'd0);
        tick(2);
        ifa.acceptedB = 1'b1;
        tick(1);
        chk("basic_done", {63'd0, ifa.doneA}, 64'd1);
        ifa.acceptedB = 1'b0;
        tick(1);
        chk("basic_done_pulse", {63'd0, ifa.doneA}, 64'd0);
        tick(2);

        // Back-to-back with acceptedB tied high
        ifa.data64 = 64'h1122_3344_5566_7788;
        ifa.wordValid = 1'b1;
        ifa.acceptedB = 1'b1;
        tick(1);
        chk("b2b_first_accept", {63'd0, ifa.wordAccepted}, 64'd1);
        ifa.data64 = 64'hF0E1_D2C3_B4A5_9687;
        gap = 0;
        for (int i = 1; i <= 30 && gap == 0; i++) begin
            tick(1);
            if (ifa.wordAccepted) gap = i;
        end
        chk("b2b_accept_spacing", 64'(gap), 64'd10);
        ifa.wordValid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            if (ifa.doneA) seen = 1'b1;
        end
        chk("b2b_second_done", {63'd0, seen}, 64'd1);
        ifa.acceptedB = 1'b0;
        tick(2);

        // Stray inputs; acknowledge lands on the 4th WAIT_ACK cycle
        ifa.data64 = 64'hA5A5_5A5A_0F0F_F0F0;
        ifa.wordValid = 1'b1;
        tick(1);
        chk("stray_accept", {63'd0, ifa.wordAccepted}, 64'd1);
        ifa.wordValid = 1'b0;
        tick(2);
        ifa.acceptedB = 1'b1;
        tick(1);
        ifa.acceptedB = 1'b0;
        chk("stray_byte3", {56'd0, ifa.sharedBus}, 64'h5A);
        tick(5);
        chk("stray_wait_readyA", {63'd0, ifa.readyA}, 64'd0);
        ifa.wordValid = 1'b1;
        tick(1);
        ifa.wordValid = 1'b0;
        tick(1);
        ifa.wordValid = 1'b1;
        tick(1);
        ifa.wordValid = 1'b0;
        ifa.acceptedB = 1'b1;
        chk("stray_no_done_yet", {63'd0, ifa.doneA},        64'd0);
        chk("stray_no_reaccept", {63'd0, ifa.wordAccepted}, 64'd0);
        tick(1);
        ifa.acceptedB = 1'b0;
        chk("stray_last_cycle_done", {63'd0, ifa.doneA}, 64'd1);
        chk("stray_last_cycle_err",  {63'd0, ifa.errA},  64'd0);
        tick(2);

        // Reset after byte 3
        ifa.data64 = 64'hDEAD_BEEF_CAFE_F00D;
        ifa.wordValid = 1'b1;
        tick(1);
        ifa.wordValid = 1'b0;
        tick(3);
        chk("rst_pre_byte3", {56'd0, ifa.sharedBus}, 64'hEF);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_readyA", {63'd0, ifa.readyA},    64'd0);
        chk("rst_bus",    {56'd0, ifa.sharedBus}, 64'd0);
        tick(12);
        chk("rst_no_done", {63'd0, ifa.doneA}, 64'd0);
        ifa.data64 = 64'h0011_2233_4455_6677;
        ifa.wordValid = 1'b1;
        tick(1);
        chk("rst_fresh_accept", {63'd0, ifa.wordAccepted}, 64'd1);
        chk("rst_fresh_byte0",  {56'd0, ifa.sharedBus},    64'h00);
        ifa.wordValid = 1'b0;
        tick(7);
        chk("rst_fresh_byte7", {56'd0, ifa.sharedBus}, 64'h77);
        tick(1);
        ifa.acceptedB = 1'b1;
        tick(2);
        ifa.acceptedB = 1'b0;
        tick(2);

        // Missing acknowledge
        ifa.data64 = 64'h8000_0000_0000_0001;
        ifa.wordValid = 1'b1;
        tick(1);
        ifa.wordValid = 1'b0;
        tick(8);
`ifdef DEVA_TIMEOUT_EN
        tick(4);
        chk("timeout_err",     {63'd0, ifa.errA},  64'd1);
        chk("timeout_no_done", {63'd0, ifa.doneA}, 64'd0);
        tick(1);
        chk("timeout_err_pulse", {63'd0, ifa.errA}, 64'd0);
`else
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("noack_errA", {63'd0, ifa.errA},  64'd0);
            chk("noack_done", {63'd0, ifa.doneA}, 64'd0);
        end
        ifa.acceptedB = 1'b1;
        tick(1);
        ifa.acceptedB = 1'b0;
        chk("noack_late_done", {63'd0, ifa.doneA}, 64'd1);
`endif
        tick(1);
        ifa.data64 = 64'h7E7E_7E7E_7E7E_7E7E;
        ifa.wordValid = 1'b1;
        tick(1);
        chk("after_abort_accept", {63'd0, ifa.wordAccepted}, 64'd1);
        ifa.wordValid = 1'b0;
        ifa.acceptedB = 1'b1;
        tick(10);
        ifa.acceptedB = 1'b0;
        tick(2);

        // Two-byte instance
        ifb.data64 = 16'hBEEF;
        ifb.wordValid = 1'b1;
        tick(1);
        chk("nb2_accept", {63'd0, ifb.wordAccepted}, 64'd1);
        chk("nb2_rdy0",   {63'd0, ifb.readyA},       64'd1);
        chk("nb2_byte0",  {56'd0, ifb.sharedBus},    64'hBE);
        ifb.wordValid = 1'b0;
        tick(1);
        chk("nb2_rdy1",  {63'd0, ifb.readyA},    64'd1);
        chk("nb2_byte1", {56'd0, ifb.sharedBus}, 64'hEF);
        tick(1);
        chk("nb2_rdy_low",  {63'd0, ifb.readyA},    64'd0);
        chk("nb2_bus_zero", {56'd0, ifb.sharedBus}, 64'd0);
        ifb.acceptedB = 1'b1;
        tick(1);
        ifb.acceptedB = 1'b0;
        chk("nb2_done", {63'd0, ifb.doneA}, 64'd1);
        chk("nb2_err",  {63'd0, ifb.errA},  64'd0);
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
